// File: rtl/lcd_readback.sv
// Read-side controller for an HD44780-style 8-bit LCD bus. It performs RW=1 bus cycles:
// status reads, busy polling with a timeout, and DDRAM readback at a chosen address.
module lcd_readback #(
  parameter int unsigned EN_CYCLES    = 1,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic       clk_LCD,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [6:0] cmd_addr,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [6:0] rsp_ac,
  output logic       rsp_timeout,
  output logic       en,
  output logic       RS,
  output logic       RW,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [7:0] db_in
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR_WR, S_POLL, S_DATA_RD, S_DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_HOLD} phase_t;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WAIT   = 2'b10;

  state_t     r_state;
  phase_t     r_phase;
  logic       r_pend;
  logic [1:0] r_op;
  logic [6:0] r_addr;
  logic [3:0] r_en_cnt;
  logic [7:0] r_poll_cnt;
  logic [7:0] r_status;
  logic [7:0] r_data;

  logic w_poll_done;
  logic w_poll_expired;
  logic w_en_last;

  // A status-only read ends after one poll whatever BF says.
  assign w_poll_done    = (r_op == OP_STATUS) || !r_status[7];
  assign w_poll_expired = (r_poll_cnt == 8'(BUSY_TIMEOUT));
  assign w_en_last      = (r_en_cnt == 4'(EN_CYCLES));

  always_ff @(posedge clk_LCD) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_SETUP;
      r_pend      <= 1'b0;
      r_op        <= 2'b00;
      r_addr      <= 7'h00;
      r_en_cnt    <= 4'd0;
      r_poll_cnt  <= 8'd0;
      r_status    <= 8'h00;
      r_data      <= 8'h00;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_ac      <= 7'h00;
      rsp_timeout <= 1'b0;
      en          <= 1'b0;
      RS          <= 1'b0;
      RW          <= 1'b1;
      db_out      <= 8'h00;
      db_oe       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          en    <= 1'b0;
          RS    <= 1'b0;
          RW    <= 1'b1;
          db_oe <= 1'b0;
          if (r_pend) begin
            r_pend     <= 1'b0;
            r_poll_cnt <= 8'd0;
            r_phase    <= PH_SETUP;
            case (r_op)
              OP_STATUS, OP_WAIT: begin
                r_state <= S_POLL;
                db_out  <= 8'h00;
              end
              OP_READ: begin
                r_state <= S_ADDR_WR;
                RW      <= 1'b0;
                db_oe   <= 1'b1;
                db_out  <= {1'b1, r_addr};
              end
              default: begin
                r_state     <= S_DONE;
                rsp_valid   <= 1'b1;
                rsp_data    <= 8'h00;
                rsp_ac      <= 7'h00;
                rsp_timeout <= 1'b1;
              end
            endcase
          end else if (cmd_ready && cmd_valid) begin
            r_op      <= cmd_op;
            r_addr    <= cmd_addr;
            r_pend    <= 1'b1;
            cmd_ready <= 1'b0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_DONE: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: begin
          case (r_phase)
            PH_SETUP: begin
              en       <= 1'b1;
              r_en_cnt <= 4'd1;
              r_phase  <= PH_HIGH;
            end
            PH_HIGH: begin
              if (w_en_last) begin
                en      <= 1'b0;
                r_phase <= PH_HOLD;
                if (r_state == S_DATA_RD) begin
                  r_data <= db_in;
                end else if (r_state == S_POLL) begin
                  r_status   <= db_in;
                  r_poll_cnt <= r_poll_cnt + 8'd1;
                end
              end else begin
                r_en_cnt <= r_en_cnt + 4'd1;
              end
            end
            default: begin
              // End of HOLD: launch the next bus cycle's SETUP or finish the command.
              r_phase <= PH_SETUP;
              case (r_state)
                S_ADDR_WR: begin
                  r_state <= S_POLL;
                  RS      <= 1'b0;
                  RW      <= 1'b1;
                  db_oe   <= 1'b0;
                  db_out  <= 8'h00;
                end
                S_POLL: begin
                  if (w_poll_done && (r_op == OP_READ)) begin
                    r_state <= S_DATA_RD;
                    RS      <= 1'b1;
                    RW      <= 1'b1;
                    db_oe   <= 1'b0;
                  end else if (w_poll_done || w_poll_expired) begin
                    r_state     <= S_DONE;
                    rsp_valid   <= 1'b1;
                    rsp_data    <= r_status;
                    rsp_ac      <= r_status[6:0];
                    rsp_timeout <= !w_poll_done;
                  end
                end
                default: begin
                  r_state     <= S_DONE;
                  RS          <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_data    <= r_data;
                  rsp_ac      <= r_status[6:0];
                  rsp_timeout <= 1'b0;
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_readback.sv
// Bench for lcd_readback: a bus responder plays the LCD, a scoreboard queue holds expected
// responses, and directed steps cover status reads, busy polling, DDRAM readback and reset.
module tb_lcd_readback;

  localparam int EN = 1;
  localparam int TO = 5;

  logic       clk_LCD = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [6:0] cmd_addr = 7'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [6:0] rsp_ac;
  logic       rsp_timeout;
  logic       en, RS, RW;
  logic [7:0] db_out;
  logic       db_oe;
  logic [7:0] db_in = 8'h00;

  lcd_readback #(.EN_CYCLES(EN), .BUSY_TIMEOUT(TO)) dut (
    .clk_LCD(clk_LCD), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ac(rsp_ac), .rsp_timeout(rsp_timeout),
    .en(en), .RS(RS), .RW(RW), .db_out(db_out), .db_oe(db_oe), .db_in(db_in)
  );

  always #5 clk_LCD = ~clk_LCD;

  typedef struct packed {logic rs; logic rw; logic oe; logic [7:0] dout; logic [7:0] rd;} bus_t;
  typedef struct packed {logic [7:0] d; logic [6:0] ac; logic to; logic [15:0] lat;} rsp_t;

  bus_t bq[$];
  rsp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int pulses = 0;
  int hi_cnt = 0;
  logic p_en = 1'b0, p_rs = 1'b0, p_rw = 1'b1, p_oe = 1'b0, p_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept edges are recorded from the pre-edge values of the handshake.
  always @(posedge clk_LCD) begin
    cyc = cyc + 1;
    if (cmd_valid && cmd_ready && !rst) acc_cyc = cyc;
  end

  // LCD model and protocol checks.
  always @(negedge clk_LCD) begin
    bus_t e;
    if (RW) chk("oe_low_when_read", db_oe, 1'b0);
    if (en) begin
      chk("rs_stable", RS, p_rs);
      chk("rw_stable", RW, p_rw);
      chk("oe_stable", db_oe, p_oe);
      hi_cnt++;
    end else if (p_en) begin
      chk("en_width", hi_cnt, EN);
      hi_cnt = 0;
    end
    if (en && !p_en) begin
      pulses++;
      if (bq.size() == 0) begin
        chk("unexpected_en_pulse", 1, 0);
      end else begin
        e = bq.pop_front();
        chk("bus_rs", RS, e.rs);
        chk("bus_rw", RW, e.rw);
        chk("bus_oe", db_oe, e.oe);
        if (e.oe) chk("bus_dout", db_out, e.dout);
        db_in = e.rd;
      end
    end
    p_en = en; p_rs = RS; p_rw = RW; p_oe = db_oe;
  end

  // Response scoreboard.
  always @(negedge clk_LCD) begin
    rsp_t r;
    if (p_rv) chk("ready_after_rsp", cmd_ready, 1'b1);
    if (rsp_valid) begin
      chk("ready_low_in_done", cmd_ready, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        r = sb.pop_front();
        chk("rsp_data", rsp_data, r.d);
        chk("rsp_ac", rsp_ac, r.ac);
        chk("rsp_timeout", rsp_timeout, r.to);
        chk("rsp_latency", 32'(cyc - acc_cyc), 32'(r.lat));
      end
    end
    p_rv = rsp_valid;
  end

  task automatic rd(input logic rs, input logic [7:0] val);
    bq.push_back({rs, 1'b1, 1'b0, 8'h00, val});
  endtask

  task automatic wr_addr(input logic [7:0] dout);
    bq.push_back({1'b0, 1'b0, 1'b1, dout, 8'h00});
  endtask

  task automatic expect_rsp(input logic [7:0] d, input logic [6:0] ac, input logic to, input int lat);
    sb.push_back({d, ac, to, 16'(lat)});
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] addr);
    cmd_op = op; cmd_addr = addr; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk_LCD);
    chk("accept_ready", cmd_ready, 1'b1);
    @(negedge clk_LCD);
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_op = 2'b11;
  endtask

  task automatic wait_idle(input string tag, input int exp_pulses);
    int n = 0;
    while (!(sb.size() == 0 && bq.size() == 0 && cmd_ready) && n < 300) begin
      @(negedge clk_LCD); n++;
    end
    chk({tag, "_idle"}, (n < 300), 1'b1);
    chk({tag, "_pulses"}, pulses, exp_pulses);
    pulses = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_LCD);
    chk("rst_en", en, 1'b0);
    chk("rst_rw", RW, 1'b1);
    chk("rst_oe", db_oe, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_ac, rsp_timeout}, 17'h0);
    rst = 1'b0;
    @(negedge clk_LCD);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Status read.
    rd(1'b0, 8'h45); expect_rsp(8'h45, 7'h45, 1'b0, 4);
    issue(2'b00, 7'h00); wait_idle("op00", 1);

    // Busy three polls, then ready.
    repeat (3) rd(1'b0, 8'h80);
    rd(1'b0, 8'h10); expect_rsp(8'h10, 7'h10, 1'b0, 13);
    issue(2'b10, 7'h00); wait_idle("op10_busy3", 4);

    // Stuck busy: poll count limited.
    repeat (TO) rd(1'b0, 8'h83);
    expect_rsp(8'h83, 7'h03, 1'b1, 1 + 3 * TO);
    issue(2'b10, 7'h00); wait_idle("op10_stuck", TO);

    // DDRAM readback.
    wr_addr(8'hC2); rd(1'b0, 8'h00); rd(1'b1, 8'h4C);
    expect_rsp(8'h4C, 7'h00, 1'b0, 10);
    issue(2'b01, 7'h42); wait_idle("op01", 3);

    // Top address with poll timeout: data read skipped.
    wr_addr(8'hFF); repeat (TO) rd(1'b0, 8'hA5);
    expect_rsp(8'hA5, 7'h25, 1'b1, 1 + 3 * (TO + 1));
    issue(2'b01, 7'h7F); wait_idle("op01_timeout", TO + 1);

    // Readback after two busy polls.
    wr_addr(8'h90); rd(1'b0, 8'h80); rd(1'b0, 8'h80); rd(1'b0, 8'h05); rd(1'b1, 8'h41);
    expect_rsp(8'h41, 7'h05, 1'b0, 1 + 3 * 5);
    issue(2'b01, 7'h10); wait_idle("op01_busy2", 5);
    repeat (4) @(negedge clk_LCD);
    chk("rsp_data_hold", rsp_data, 8'h41);
    chk("rsp_ac_hold", rsp_ac, 7'h05);

    // Reset during the HIGH phase of the address write.
    wr_addr(8'hB3);
    issue(2'b01, 7'h33);
    for (int i = 0; i < 20 && !en; i++) @(negedge clk_LCD);
    chk("reached_high", en, 1'b1);
    rst = 1'b1;
    @(negedge clk_LCD);
    chk("abort_en", en, 1'b0);
    chk("abort_oe", db_oe, 1'b0);
    chk("abort_rw", RW, 1'b1);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;
    @(negedge clk_LCD);
    chk("ready_after_abort", cmd_ready, 1'b1);
    repeat (10) @(negedge clk_LCD);
    wait_idle("abort", 1);

    // Reserved op: no bus activity.
    expect_rsp(8'h00, 7'h00, 1'b1, 1);
    issue(2'b11, 7'h55); wait_idle("op11", 0);

    // Request held while busy is taken only once cmd_ready returns.
    wr_addr(8'h85); rd(1'b0, 8'h00); rd(1'b1, 8'h55);
    expect_rsp(8'h55, 7'h00, 1'b0, 10);
    rd(1'b0, 8'h12); expect_rsp(8'h12, 7'h12, 1'b0, 4);
    issue(2'b01, 7'h05);
    cmd_op = 2'b00; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk_LCD);
    chk("held_ready", cmd_ready, 1'b1);
    @(negedge clk_LCD);
    cmd_valid = 1'b0;
    wait_idle("held", 4);
    repeat (20) @(negedge clk_LCD);
    chk("held_no_extra", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
